key_expand_ctrl: RTL and testbench
==================================

KEY_EXPAND_CTRL -- requirements
Module: key_expand_ctrl

Interface
REQ-001 The block SHALL have the parameter WORD_WIDTH, default 32, giving the round-key word width; only 32 is supported.
REQ-002 The block SHALL have the parameter RF_LATENCY, default 4, giving the cycles from round-function input sampling to a valid k_4 output.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have the port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have the port start, input, 1 bit: request an expansion of mk; sampled only in IDLE.
REQ-006 The block SHALL have the port mk, input, 128 bits: the master key, MK0 in [127:96]; sampled on the accepting edge.
REQ-007 The block SHALL have the port busy, output, 1 bit: high while in RUN.
REQ-008 The block SHALL have the port done, output, 1 bit: a one-cycle pulse when round key 31 is presented.
REQ-009 The block SHALL have the port ck, output, 32 bits: the CK constant for the current round, driving the round function.
REQ-010 The block SHALL have the ports k_0_out, k_1_out, k_2_out and k_3_out, output, 32 bits each: the key window driving the round function.
REQ-011 The block SHALL have the port k_4_in, input, 32 bits: the result returned by the round function.
REQ-012 The block SHALL have the port rk_valid, output, 1 bit: one-cycle strobe qualifying rk and rk_idx.
REQ-013 The block SHALL have the port rk, output, 32 bits: the newly produced round key.
REQ-014 The block SHALL have the port rk_idx, output, 5 bits: the index (0..31) of rk.

Function
REQ-015 The FSM SHALL have states IDLE and RUN; in IDLE, start=1 SHALL load the window {k0,k1,k2,k3} with mk XOR FK (FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC, K0 first), clear the round counter and the latency counter cnt, and enter RUN.
REQ-016 In RUN, the window and ck SHALL be held stable, and cnt SHALL increment by one every cycle.
REQ-017 In the RUN cycle where cnt equals RF_LATENCY, k_4_in SHALL be captured, and the window SHALL shift to {k1,k2,k3,k_4_in}.
REQ-018 On that same capture edge, cnt SHALL clear to 0 and the round counter SHALL increment.
REQ-019 Each round SHALL take RF_LATENCY+1 cycles, so a full expansion takes 32*(RF_LATENCY+1) RUN cycles.
REQ-020 The cycle after each capture, rk_valid SHALL be 1, rk SHALL hold the captured word, and rk_idx SHALL hold its round index.
REQ-021 In every other cycle, rk_valid SHALL be 0, and rk and rk_idx SHALL hold their last values.
REQ-022 The capture of round 31 SHALL move the FSM to IDLE and make done=1 in the same cycle as rk_valid for index 31.
REQ-023 ck SHALL be combinational from the round counter r: byte j (j=0 is the MSB) equals (28*r + 7*j) mod 256, e.g. r=0 gives 00070E15 and r=31 gives 646B7279.
REQ-024 start SHALL be ignored while in RUN; start SHALL be accepted in the done cycle, since the FSM is already in IDLE then.
REQ-025 A change of mk while in RUN SHALL have no effect on the expansion in progress.

Reset
REQ-026 While rst_n=0, the FSM SHALL be in IDLE, and all counters, the window, rk, rk_idx, rk_valid, done and busy SHALL be 0.
REQ-027 Reset asserted in the middle of an expansion SHALL abort it immediately with no rk_valid or done pulse; after release, the block SHALL wait for a new start.

Configuration
REQ-028 The macro SM4_RK_STORE_EN, when defined, SHALL add a 32x32 key store written at each rk_valid, indexed by rk_idx.
REQ-029 With SM4_RK_STORE_EN defined, the block SHALL add the ports rk_rd_addr (input, 5 bits) and rk_rd_data (output, 32 bits), with a registered read of latency 1; the store SHALL be reset to 0 and retain its contents after done.
REQ-030 Without SM4_RK_STORE_EN, the store and both read ports SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 The bench SHALL connect the block to the round function and check: reset, then start with mk=0123456789ABCDEFFEDCBA9876543210 -> rk_idx0 = F12186F9, rk_idx31 = 9124A012, done in the same cycle as index 31.
REQ-032 The bench SHALL check timing with RF_LATENCY=4: start accepted at edge 0 -> first rk_valid in cycle 6, busy high in cycles 1..160, done in cycle 161, exactly 32 rk_valid pulses.
REQ-033 The bench SHALL check that start pulsed at round 10, and mk changed at the same time, do not alter or restart the expansion; it SHALL also check that start asserted in the done cycle begins a new expansion at the next edge.
REQ-034 The bench SHALL check that rst_n asserted at round 15 gives all outputs 0 at once and no done; a fresh start after reset then gives the correct 32 keys.
REQ-035 The bench SHALL check ck: during round 0 it equals 00070E15, during round 1 it equals 1C232A31, and during round 31 it equals 646B7279.
REQ-036 The bench SHALL check, with SM4_RK_STORE_EN defined and after done: rk_rd_addr=0 -> rk_rd_data=F12186F9 on the next cycle, and rk_rd_addr=31 -> rk_rd_data=9124A012.

Source files
------------

// File: rtl/key_expand_ctrl.sv
// key_expand_ctrl: SM4 key-expansion sequencer around an external round function.
// Define SM4_RK_STORE_EN to add a 32x32 round-key store with a registered read port.
module key_expand_ctrl #(
  parameter int WORD_WIDTH = 32,
  parameter int RF_LATENCY = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [4*WORD_WIDTH-1:0]   mk,
  output logic                      busy,
  output logic                      done,
  output logic [WORD_WIDTH-1:0]     ck,
  output logic [WORD_WIDTH-1:0]     k_0_out,
  output logic [WORD_WIDTH-1:0]     k_1_out,
  output logic [WORD_WIDTH-1:0]     k_2_out,
  output logic [WORD_WIDTH-1:0]     k_3_out,
  input  logic [WORD_WIDTH-1:0]     k_4_in,
  output logic                      rk_valid,
  output logic [WORD_WIDTH-1:0]     rk,
  output logic [4:0]                rk_idx
`ifdef SM4_RK_STORE_EN
  ,
  input  logic [4:0]                rk_rd_addr,
  output logic [WORD_WIDTH-1:0]     rk_rd_data
`endif
);
  localparam int CW = $clog2(RF_LATENCY + 2);
  localparam logic [4*WORD_WIDTH-1:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
  typedef enum logic {IDLE, RUN} state_t;
  state_t                r_state;
  logic [WORD_WIDTH-1:0] r_k0, r_k1, r_k2, r_k3;
  logic [CW-1:0]         r_cnt;
  logic [4:0]            r_round;
  logic                  r_busy, r_done, r_rk_valid;
  logic [WORD_WIDTH-1:0] r_rk;
  logic [4:0]            r_rk_idx;
  logic                  w_capture;
  assign w_capture = (r_state == RUN) && (r_cnt == CW'(RF_LATENCY));
  // CK byte j of round r is (28*r + 7*j) mod 256, MSB first
  always_comb begin
    ck = '0;
    for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(28 * r_round + 7 * j);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      {r_k0, r_k1, r_k2, r_k3} <= '0;
      r_cnt      <= '0;
      r_round    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rk_valid <= 1'b0;
      r_rk       <= '0;
      r_rk_idx   <= '0;
    end else begin
      r_rk_valid <= 1'b0;
      r_done     <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          {r_k0, r_k1, r_k2, r_k3} <= mk ^ FK;
          r_cnt   <= '0;
          r_round <= '0;
          r_busy  <= 1'b1;
          r_state <= RUN;
        end
      end else if (w_capture) begin
        {r_k0, r_k1, r_k2, r_k3} <= {r_k1, r_k2, r_k3, k_4_in};
        r_rk       <= k_4_in;
        r_rk_idx   <= r_round;
        r_rk_valid <= 1'b1;
        r_cnt      <= '0;
        r_round    <= r_round + 5'd1;
        if (r_round == 5'd31) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
  assign busy     = r_busy;
  assign done     = r_done;
  assign rk_valid = r_rk_valid;
  assign rk       = r_rk;
  assign rk_idx   = r_rk_idx;
  assign k_0_out  = r_k0;
  assign k_1_out  = r_k1;
  assign k_2_out  = r_k2;
  assign k_3_out  = r_k3;
`ifdef SM4_RK_STORE_EN
  logic [WORD_WIDTH-1:0] r_store [32];
  logic [WORD_WIDTH-1:0] r_rd_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_store[i] <= '0;
      r_rd_data <= '0;
    end else begin
      if (r_rk_valid) r_store[r_rk_idx] <= r_rk;
      r_rd_data <= r_store[rk_rd_addr];
    end
  end
  assign rk_rd_data = r_rd_data;
`endif
endmodule

// File: tb/tb_key_expand_ctrl.sv
// tb_key_expand_ctrl: drives key_expand_ctrl with a pipelined SM4 round function
// and checks round keys, timing and control against a plain SM4 key-schedule model.
module tb_key_expand_ctrl;
  localparam int LAT = 4;
  localparam logic [127:0] SPEC_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
  localparam logic [7:0] SBOX [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48};
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] mk = '0;
  logic         busy, done, rk_valid;
  logic [31:0]  ck, k_0_out, k_1_out, k_2_out, k_3_out, k_4_in, rk;
  logic [4:0]   rk_idx;
`ifdef SM4_RK_STORE_EN
  logic [4:0]   rk_rd_addr = '0;
  logic [31:0]  rk_rd_data;
`endif
  logic [31:0]  rf_pipe [LAT];
  logic [31:0]  exp_rk [32];
  logic [31:0]  got_rk [32];
  int           n_chk = 0;
  int           n_pass = 0;
  key_expand_ctrl #(.WORD_WIDTH(32), .RF_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mk(mk), .busy(busy), .done(done),
    .ck(ck), .k_0_out(k_0_out), .k_1_out(k_1_out), .k_2_out(k_2_out), .k_3_out(k_3_out),
    .k_4_in(k_4_in), .rk_valid(rk_valid), .rk(rk), .rk_idx(rk_idx)
`ifdef SM4_RK_STORE_EN
    , .rk_rd_addr(rk_rd_addr), .rk_rd_data(rk_rd_data)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] t_prime(input logic [31:0] x);
    logic [31:0] b;
    b = {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction
  // Round function: LAT-stage pipeline, result valid LAT edges after the window settles
  always @(posedge clk) begin
    rf_pipe[0] <= k_0_out ^ t_prime(k_1_out ^ k_2_out ^ k_3_out ^ ck);
    for (int i = 1; i < LAT; i++) rf_pipe[i] <= rf_pipe[i-1];
  end
  assign k_4_in = rf_pipe[LAT-1];
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic ref_expand(input logic [127:0] key);
    logic [31:0] k [36];
    logic [31:0] cki;
    logic [127:0] w;
    w = key ^ FK;
    for (int i = 0; i < 4; i++) k[i] = w[127-32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) cki[31-8*j -: 8] = 8'((28 * i + 7 * j) % 256);
      k[i+4] = k[i] ^ t_prime(k[i+1] ^ k[i+2] ^ k[i+3] ^ cki);
      exp_rk[i] = k[i+4];
    end
  endtask
  // mode 0: plain run; mode 1: start+mk change at round 10; mode 2: reset at round 15
  task automatic run(input logic [127:0] key, input bit pre, input int mode,
                     input bit chain, input logic [127:0] nkey);
    int n;
    logic [127:0] w;
    n = 0;
    w = key ^ FK;
    ref_expand(key);
    if (!pre) begin
      start = 1'b1;
      mk = key;
    end
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 161; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      if (mode == 2 && c == 76) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rk_valid", rk_valid, 0);
        check("rst_rk", rk, 0);
        check("rst_rk_idx", rk_idx, 0);
        check("rst_window", {k_0_out, k_1_out, k_2_out, k_3_out}, 0);
        repeat (2) begin
          @(posedge clk); #1;
          check("rst_hold", {rk_valid, done, busy}, 0);
        end
        rst_n = 1'b1;
        repeat (8) begin
          @(posedge clk); #1;
          check("post_rst_idle", {rk_valid, done, busy}, 0);
        end
        return;
      end
      check("busy", busy, c <= 160);
      check("done", done, c == 161);
      check("rk_valid", rk_valid, c >= 6 && (c - 6) % 5 == 0);
      if (c == 1) begin
        check("ck_r0", ck, 32'h00070E15);
        check("win_load", {k_0_out, k_1_out, k_2_out, k_3_out}, w);
      end
      if (c == 6) check("ck_r1", ck, 32'h1C232A31);
      if (c == 156) check("ck_r31", ck, 32'h646B7279);
      if (rk_valid) begin
        check("rk", rk, exp_rk[n]);
        check("rk_idx", rk_idx, n);
        got_rk[rk_idx] = rk;
        n++;
      end
      if (mode == 1 && c == 51) begin
        start = 1'b1;
        mk = {$urandom, $urandom, $urandom, $urandom};
      end
      if (mode == 1 && c == 52) start = 1'b0;
      if (chain && c == 161) begin
        start = 1'b1;
        mk = nkey;
      end
    end
    check("n_keys", n, 32);
  endtask
  initial begin
    logic [127:0] k2;
    #1;
    check("init_busy", busy, 0);
    check("init_done", done, 0);
    check("init_rk_valid", rk_valid, 0);
    check("init_rk", rk, 0);
    check("init_rk_idx", rk_idx, 0);
    check("init_window", {k_0_out, k_1_out, k_2_out, k_3_out}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run(SPEC_KEY, 0, 0, 0, '0);
    check("rk0_const", got_rk[0], 32'hF12186F9);
    check("rk31_const", got_rk[31], 32'h9124A012);
`ifdef SM4_RK_STORE_EN
    rk_rd_addr = 5'd0;
    @(posedge clk); #1;
    check("store_rd0", rk_rd_data, 32'hF12186F9);
    rk_rd_addr = 5'd31;
    @(posedge clk); #1;
    check("store_rd31", rk_rd_data, 32'h9124A012);
`endif
    k2 = {$urandom, $urandom, $urandom, $urandom};
    run({$urandom, $urandom, $urandom, $urandom}, 0, 1, 1, k2);
    run(k2, 1, 0, 0, '0);
    run({$urandom, $urandom, $urandom, $urandom}, 0, 2, 0, '0);
    run({$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, '0);
    run(SPEC_KEY, 0, 0, 0, '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
